// File: rtl/seq_det_serializer.sv
// Parallel-to-serial front end for the 1011 sequence detector: one-word skid
// buffer in front of a bit_en-paced shift register with registered serial outputs.
module seq_det_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  output logic              out_bit,
  output logic              out_bit_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] hold;
  logic              sreg_last;
  logic              hold_last;
  logic              hold_full;
  logic [CNT_W-1:0]  cnt;

  logic              emit;
  logic              last_edge;
  logic              accept;
  logic              cur_bit;
  logic [DATA_W-1:0] sreg_shifted;

  assign in_ready  = !hold_full;
  assign busy      = (state == SHIFT) || hold_full;
  assign emit      = (state == SHIFT) && bit_en;
  assign last_edge = emit && (cnt == CNT_MAX);
  assign accept    = in_valid && !hold_full;

  generate
    if (MSB_FIRST) begin : g_msb
      assign cur_bit      = sreg[DATA_W-1];
      assign sreg_shifted = {sreg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb
      assign cur_bit      = sreg[0];
      assign sreg_shifted = {1'b0, sreg[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      hold_full     <= 1'b0;
      out_bit       <= IDLE_BIT;
      out_bit_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      out_bit       <= IDLE_BIT;
      out_bit_valid <= 1'b0;
      frame_done    <= 1'b0;

      if (emit) begin
        out_bit       <= cur_bit;
        out_bit_valid <= 1'b1;
        frame_done    <= last_edge && sreg_last;
        sreg          <= sreg_shifted;
        cnt           <= cnt + CNT_W'(1);
      end

      // The last-bit edge refills sreg from hold or straight from the input,
      // so consecutive words leave no gap on out_bit_valid.
      if (last_edge) begin
        cnt <= '0;
        if (hold_full) begin
          sreg      <= hold;
          sreg_last <= hold_last;
          hold_full <= 1'b0;
        end else if (accept) begin
          sreg      <= in_data;
          sreg_last <= in_last;
        end else begin
          state <= IDLE;
        end
      end else if (accept) begin
        if (state == IDLE) begin
          sreg      <= in_data;
          sreg_last <= in_last;
          cnt       <= '0;
          state     <= SHIFT;
        end else begin
          hold      <= in_data;
          hold_last <= in_last;
          hold_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_serializer.sv
// Scoreboard bench for seq_det_serializer: MSB-first and LSB-first instances
// share stimulus; a reference 1011 detector checks the end-to-end hit positions.
module tb_seq_det_serializer;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         bit_en = 1'b1;
  logic         in_ready, out_bit, out_bit_valid, frame_done, busy;
  logic         in_ready_l, out_bit_l, out_bit_valid_l, frame_done_l, busy_l;

  int n_checks = 0;
  int n_fail = 0;

  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  bit         mon_en = 1'b0;
  bit         throttle = 1'b0;
  logic       en_prev = 1'b1;
  int         run_len = 0;
  int         max_run = 0;
  int         det_state = 0;
  int         det_idx = 0;
  int         det_hits[$];

  always #5 clock = ~clock;

  seq_det_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clock(clock), .rst(rst), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .bit_en(bit_en),
    .out_bit(out_bit), .out_bit_valid(out_bit_valid),
    .frame_done(frame_done), .busy(busy)
  );

  seq_det_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clock(clock), .rst(rst), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready_l), .bit_en(bit_en),
    .out_bit(out_bit_l), .out_bit_valid(out_bit_valid_l),
    .frame_done(frame_done_l), .busy(busy_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // bit_en pacing: always on, or one cycle in three when throttled.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clock);
      #1;
      ph = (ph + 1) % 3;
      bit_en = throttle ? (ph == 0) : 1'b1;
    end
  end

  // Monitor: compares emitted bits against the queues, then records the
  // word that will be accepted at the coming edge.
  always @(negedge clock) begin
    logic [1:0] e;
    if (mon_en) begin
      if (out_bit_valid) begin
        check_eq("en_align", en_prev, 1);
        check_eq("msb_q_nonempty", q_m.size() != 0, 1);
        if (q_m.size() != 0) begin
          e = q_m.pop_front();
          check_eq("msb_bit", out_bit, e[1]);
          check_eq("msb_frame_done", frame_done, e[0]);
          $display("bit msb=%0d frame_done=%0d", out_bit, frame_done);
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
        det_idx++;
        case (det_state)
          0: det_state = out_bit ? 1 : 0;
          1: det_state = out_bit ? 1 : 2;
          2: det_state = out_bit ? 3 : 0;
          default: begin
            if (out_bit) det_hits.push_back(det_idx);
            det_state = out_bit ? 1 : 2;
          end
        endcase
      end else begin
        run_len = 0;
        check_eq("msb_idle_frame_done", frame_done, 0);
        check_eq("msb_idle_bit", out_bit, 0);
      end
      if (out_bit_valid_l) begin
        check_eq("lsb_q_nonempty", q_l.size() != 0, 1);
        if (q_l.size() != 0) begin
          e = q_l.pop_front();
          check_eq("lsb_bit", out_bit_l, e[1]);
          check_eq("lsb_frame_done", frame_done_l, e[0]);
        end
      end else begin
        check_eq("lsb_idle_frame_done", frame_done_l, 0);
      end
      if (!rst && in_valid && in_ready) begin
        for (int k = W - 1; k >= 0; k--) q_m.push_back({in_data[k], in_last && (k == 0)});
        for (int k = 0; k < W; k++) q_l.push_back({in_data[k], in_last && (k == W - 1)});
      end
    end
    en_prev = bit_en;
  end

  task automatic send_word(input logic [W-1:0] d, input logic l);
    int n = 0;
    logic rdy;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    do begin
      @(negedge clock);
      rdy = in_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!rdy && n < 200);
    check_eq("send_timeout", rdy, 1);
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while ((busy || busy_l || out_bit_valid || out_bit_valid_l) && n < 300);
    check_eq("drain_busy", busy, 0);
    @(posedge clock);
    #1;
    check_eq("drain_q_empty", q_m.size() + q_l.size(), 0);
    check_eq("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    int nb;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_valid", out_bit_valid, 0);
    check_eq("rst_out_bit", out_bit, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Single word with latency check
    max_run = 0;
    send_word(8'hB4, 1'b1);
    @(negedge clock);
    check_eq("lat_first_cycle", out_bit_valid, 0);
    @(negedge clock);
    check_eq("lat_second_cycle", out_bit_valid, 1);
    drain();
    check_eq("single_run", max_run, 8);
    $display("txn single B4 done");

    // Back-to-back
    max_run = 0;
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b0);
    send_word(8'hA5, 1'b1);
    check_eq("b2b_hold_full_ready", in_ready, 0);
    check_eq("b2b_busy", busy, 1);
    drain();
    check_eq("b2b_run", max_run, 24);
    $display("txn back-to-back FF 00 A5 done");

    // Throttled
    max_run = 0;
    throttle = 1'b1;
    send_word(8'h3C, 1'b1);
    drain();
    throttle = 1'b0;
    check_eq("throttle_run", max_run, 1);
    $display("txn throttled 3C done");

    // Reset mid-word after three bits
    send_word(8'hFF, 1'b1);
    nb = 0;
    for (int i = 0; i < 50 && nb < 3; i++) begin
      @(posedge clock);
      #1;
      if (out_bit_valid) nb++;
    end
    check_eq("rst_mid_bits", nb, 3);
    rst = 1'b1;
    @(posedge clock);
    #1;
    q_m.delete();
    q_l.delete();
    check_eq("rst_mid_valid", out_bit_valid, 0);
    check_eq("rst_mid_out_bit", out_bit, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_busy_l", busy_l, 0);
    rst = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    $display("txn reset mid-word done");

    // End-to-end with the reference detector
    det_state = 0;
    det_idx = 0;
    det_hits.delete();
    send_word(8'hDB, 1'b1);
    drain();
    check_eq("det_hit_count", det_hits.size(), 2);
    if (det_hits.size() == 2) begin
      check_eq("det_hit0", det_hits[0], 5);
      check_eq("det_hit1", det_hits[1], 8);
    end
    $display("txn detector DB done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/seq_det_serializer.md
Name: seq_det_serializer

Overview:
- Parallel-to-serial front end for the 1011 Mealy sequence detector. Drives the detector's serial input with one bit per qualified cycle.
- Accepts DATA_W-bit words over a valid/ready handshake and buffers one extra word, so consecutive words stream without gaps.
- Shifting is paced by the downstream `bit_en` strobe.
- Flags the final bit of each frame.

Parameters:
- DATA_W, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on out_bit when no bit is being presented.

Ports:
- clock  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high
- in_data  input  DATA_W  word to serialize
- in_last  input  1  word is the last of a frame
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block can accept a word this cycle
- bit_en  input  1  downstream pacing strobe; one bit is emitted per qualified cycle
- out_bit  output  1  serial data bit, connects to the detector in_bit
- out_bit_valid  output  1  out_bit carries a real data bit this cycle
- frame_done  output  1  one-cycle pulse, coincident with the last bit of an in_last word
- busy  output  1  shift register or holding buffer occupied

Behaviour:
- Storage:
  - shift register sreg[DATA_W] with flag sreg_last;
  - bit counter cnt, width $clog2(DATA_W), counting 0..DATA_W-1;
  - holding buffer hold[DATA_W] with flags hold_last and hold_full.
- State machine (2 states):
  - IDLE: sreg empty.
  - SHIFT: sreg holds a word that is being emitted.
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, hold_full=0, out_bit=IDLE_BIT, out_bit_valid=0, frame_done=0.
  - Reset mid-word discards sreg and hold contents with no partial output afterwards.
  - rst has priority over every other input.
- in_ready = !hold_full. This is combinational from a register only and never depends on in_valid.
- A word is accepted when in_valid && in_ready at a clock edge. It is routed as follows:
  - IDLE: word loads directly into sreg; cnt=0; state goes to SHIFT.
  - SHIFT, not the last bit, or no emission this edge: word goes to hold; hold_full=1.
  - SHIFT, last bit emitted this edge (cnt==DATA_W-1 && bit_en), hold empty: word loads directly into sreg; cnt=0; state stays SHIFT (no gap).
- Emission, at each edge with state==SHIFT && bit_en:
  - out_bit <= current bit: sreg[DATA_W-1] if MSB_FIRST, else sreg[0]. out_bit_valid <= 1.
  - sreg shifts toward the emitted end.
  - cnt increments.
  - frame_done <= (cnt==DATA_W-1 && sreg_last).
- At every other edge: out_bit <= IDLE_BIT, out_bit_valid <= 0, frame_done <= 0. The outputs are registered, so they are glitch-free toward the detector.
- Last-bit edge (cnt==DATA_W-1 && bit_en):
  - If hold_full: sreg <= hold, sreg_last <= hold_last, hold_full <= 0, state stays SHIFT.
  - Else, if no word is accepted at this edge: state goes to IDLE.
- Latency, with bit_en held at 1:
  - Word accepted at edge E0 in IDLE: bit k (k=0..DATA_W-1) appears on out_bit in the cycle after edge E0+1+k.
  - Back-to-back words produce a continuous out_bit_valid stream with no idle cycle.
- bit_en=0 in SHIFT: state, cnt, sreg and hold all freeze; out_bit_valid=0 that cycle.
- bit_en in IDLE is ignored.
- busy = (state==SHIFT) || hold_full.
- in_data changing while in_valid=0 has no effect. A word held valid while in_ready=0 is not captured until in_ready=1.

Test Plan:
- Single word: reset, then send in_data=8'hB4, in_last=1, bit_en=1 → out_bit sequence 1,0,1,1,0,1,0,0 on 8 consecutive out_bit_valid cycles starting 2 cycles after accept; frame_done=1 only on the 8th bit; busy drops after it.
- Back-to-back: hold in_valid with words 8'hFF, 8'h00, 8'hA5 → 24 contiguous valid bits. in_ready=0 while hold is full, and returns to 1 on each last-bit edge.
- Throttling: bit_en=1 every third cycle with word 8'h3C → exactly 8 valid bits, each one cycle wide and aligned to bit_en. Value 0,0,1,1,1,1,0,0 with no duplicates or drops.
- LSB_FIRST (MSB_FIRST=0): 8'hB4 → 0,0,1,0,1,1,0,1.
- Reset mid-word: assert rst after 3 bits of 8'hFF → next cycle out_bit_valid=0, out_bit=IDLE_BIT, in_ready=1, busy=0; no remaining bits are ever emitted.
- End-to-end with the detector: 8'hDB, MSB first → detector pattern_det asserts on serial bits 5 and 8 (overlapping 1011).
